usb_ep_buffer: RTL
==================

USB_EP_BUFFER -- requirements
Module: usb_ep_buffer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the words per endpoint; it is a power of two and at least 2.
REQ-003 Parameter NUM_EP, default 4, SHALL set the number of independent endpoint FIFOs; it is at least 1.
REQ-004 Derived widths SHALL be EP_W = max(1, clog2(NUM_EP)) and CNT_W = clog2(DEPTH)+1.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 wr_valid  input  1  SHALL request a write.
REQ-008 wr_ep  input  EP_W  SHALL select the write endpoint.
REQ-009 wr_data  input  DATA_W  SHALL carry the write word.
REQ-010 wr_ready  output  1  SHALL be high when wr_ep is in range and not full; combinational from wr_ep and current state.
REQ-011 rd_req  input  1  SHALL request a read.
REQ-012 rd_ep  input  EP_W  SHALL select the read endpoint.
REQ-013 rd_data  output  DATA_W  SHALL carry the registered read word.
REQ-014 rd_valid  output  1  SHALL pulse for one cycle when rd_data is new.
REQ-015 flush  input  1  SHALL request that endpoint flush_ep be emptied.
REQ-016 flush_ep  input  EP_W  SHALL select the endpoint to flush.
REQ-017 empty  output  NUM_EP  SHALL provide per-endpoint empty flags.
REQ-018 full  output  NUM_EP  SHALL provide per-endpoint full flags.
REQ-019 err_ovf, err_udf  output  NUM_EP each  SHALL be sticky per-endpoint overflow and underflow flags (see REQ-037).

Function
REQ-020 Each endpoint SHALL be a circular FIFO with its own wr_ptr, rd_ptr (clog2(DEPTH) bits) and count (CNT_W bits).
REQ-021 A write SHALL be accepted iff wr_valid and wr_ready: the word is stored at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
REQ-022 A read SHALL be accepted iff rd_req, rd_ep is in range, and !empty[rd_ep]: the word is taken from rd_ptr, rd_ptr increments modulo DEPTH, and count decrements.
REQ-023 Read latency SHALL be 1: rd_data and rd_valid update on the edge that accepts the read.
REQ-024 When no read is accepted, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-025 empty[n] SHALL equal (count==0); full[n] SHALL equal (count==DEPTH); both are derived from registered state only.
REQ-026 A simultaneous write and read on the same endpoint SHALL both be accepted when each condition holds on pre-edge state, leaving count unchanged.
REQ-027 A write to an empty endpoint SHALL NOT bypass to the read side; a read issued in the same cycle is rejected.
REQ-028 A full endpoint SHALL reject writes even when a read on it is accepted in the same cycle.
REQ-029 Accesses to different endpoints in the same cycle SHALL be fully independent.
REQ-030 Flush SHALL zero wr_ptr, rd_ptr and count of flush_ep, with priority over any same-cycle read or write to that endpoint; a read to that endpoint in that cycle is dropped (rd_valid=0).
REQ-031 An out-of-range endpoint index (>= NUM_EP) SHALL cause the write, read or flush to be ignored, with wr_ready=0.

Reset
REQ-032 While rst is high, all pointers and counts SHALL be 0, empty SHALL be all ones, full SHALL be 0, rd_valid SHALL be 0, and rd_data SHALL be 0.
REQ-033 While rst is high, err_ovf and err_udf SHALL be 0.
REQ-034 rst SHALL override wr_valid, rd_req and flush in the same cycle.
REQ-035 Reset mid-operation SHALL discard all stored data; storage contents are not cleared.

Configuration
REQ-036 Macro USB_EP_ERR_EN SHALL compile in the error-flag logic.
REQ-037 With USB_EP_ERR_EN defined: err_ovf[n] SHALL set on wr_valid to full endpoint n, and err_udf[n] SHALL set on rd_req to empty endpoint n; each flag clears only on rst or on flush of endpoint n.
REQ-038 Without USB_EP_ERR_EN: err_ovf and err_udf SHALL be tied to 0 and no error state is synthesised.

Verification
REQ-039 Defaults; write 0x00..0x09 to ep1, then read ep1 ten times -> rd_data 0x00..0x09 in order, each one cycle after rd_req; empty[1] high afterwards.
REQ-040 Write 16 words to ep2 -> full[2]=1, wr_ready=0 for ep2; a 17th write is dropped; ep0, ep1 and ep3 are unaffected.
REQ-041 ep3 holds 5 words; concurrent write 0xAA and read on ep3 -> count stays 5, the oldest word is returned, and 0xAA is read last.
REQ-042 Empty ep0; same-cycle write 0x5A and read on ep0 -> rd_valid=0; next-cycle read returns 0x5A.
REQ-043 ep1 holds 8 words; flush ep1 with a same-cycle read on ep1 -> rd_valid=0, empty[1]=1; rst mid-stream clears all endpoints.
REQ-044 With USB_EP_ERR_EN: write to full ep2 -> err_ovf[2]=1 until flush of ep2; read of empty ep0 -> err_udf[0]=1.

Source files
------------

// File: rtl/usb_ep_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_ep_buffer
//  Description : NUM_EP independent circular FIFOs sharing one write port,
//                one registered read port and a per-endpoint flush.
//                Optional sticky error flags compiled in with USB_EP_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_ep_buffer #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int NUM_EP = 4,
    localparam int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [EP_W-1:0]   wr_ep,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [EP_W-1:0]   rd_ep,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              flush,
    input  logic [EP_W-1:0]   flush_ep,
    output logic [NUM_EP-1:0] empty,
    output logic [NUM_EP-1:0] full,
    output logic [NUM_EP-1:0] err_ovf,
    output logic [NUM_EP-1:0] err_udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    logic [NUM_EP-1:0]             w_wr_sel;
    logic [NUM_EP-1:0]             w_rd_sel;
    logic [NUM_EP-1:0]             w_fl_hit;
    logic [NUM_EP-1:0]             w_wr_acc;
    logic [NUM_EP-1:0]             w_rd_acc;
    logic [NUM_EP-1:0][DATA_W-1:0] w_ep_word;
    logic [DATA_W-1:0]             w_rd_word;

    // Index decode against each endpoint number; out-of-range indices match none.
    for (genvar n = 0; n < NUM_EP; n++) begin : g_ep
        logic [PTR_W-1:0]  r_wr_ptr;
        logic [PTR_W-1:0]  r_rd_ptr;
        logic [CNT_W-1:0]  r_count;
        logic [DATA_W-1:0] r_mem [DEPTH];

        assign w_wr_sel[n]  = (wr_ep == EP_W'(n));
        assign w_rd_sel[n]  = (rd_ep == EP_W'(n));
        assign w_fl_hit[n]  = flush && (flush_ep == EP_W'(n));
        assign empty[n]     = (r_count == '0);
        assign full[n]      = (r_count == c_full_cnt);
        assign w_wr_acc[n]  = wr_valid && w_wr_sel[n] && !full[n] && !w_fl_hit[n];
        assign w_rd_acc[n]  = rd_req && w_rd_sel[n] && !empty[n] && !w_fl_hit[n];
        assign w_ep_word[n] = r_mem[r_rd_ptr];

        // Storage is not reset; only the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (w_wr_acc[n]) begin
                r_mem[r_wr_ptr] <= wr_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst || w_fl_hit[n]) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_acc[n]) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_rd_acc[n]) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_wr_acc[n], w_rd_acc[n]})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign wr_ready = |(w_wr_sel & ~full);

    always_comb begin
        w_rd_word = '0;
        for (int n = 0; n < NUM_EP; n++) begin
            if (w_rd_acc[n]) begin
                w_rd_word = w_ep_word[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= |w_rd_acc;
            if (|w_rd_acc) begin
                rd_data <= w_rd_word;
            end
        end
    end

`ifdef USB_EP_ERR_EN
    logic [NUM_EP-1:0] r_err_ovf;
    logic [NUM_EP-1:0] r_err_udf;

    // Flush of an endpoint wins over a same-cycle error event on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= '0;
            r_err_udf <= '0;
        end else begin
            for (int n = 0; n < NUM_EP; n++) begin
                if (w_fl_hit[n]) begin
                    r_err_ovf[n] <= 1'b0;
                    r_err_udf[n] <= 1'b0;
                end else begin
                    if (wr_valid && w_wr_sel[n] && full[n]) begin
                        r_err_ovf[n] <= 1'b1;
                    end
                    if (rd_req && w_rd_sel[n] && empty[n]) begin
                        r_err_udf[n] <= 1'b1;
                    end
                end
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    assign err_ovf = '0;
    assign err_udf = '0;
`endif

endmodule
`default_nettype wire
